// File: rtl/konark_mailbox.sv
// konark_mailbox: host-to-cluster message FIFO with an occupancy doorbell.
// Words enter from the host over a valid/ready port and leave toward the cluster
// over a second valid/ready port. count_o and irq_o are registered and always agree.
module konark_mailbox #(
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned Depth     = 8,
    localparam int unsigned CntWidth  = $clog2(Depth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] host_data_i,
    input  logic                 host_valid_i,
    output logic                 host_ready_o,
    output logic [DataWidth-1:0] cl_data_o,
    output logic                 cl_valid_o,
    input  logic                 cl_ready_i,
    input  logic                 flush_i,
    input  logic                 irq_en_i,
    input  logic [CntWidth-1:0]  irq_thresh_i,
    output logic [CntWidth-1:0]  count_o,
    output logic                 irq_o
);

    localparam int unsigned         PtrWidth = $clog2(Depth);
    localparam logic [CntWidth-1:0] Full     = CntWidth'(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [CntWidth-1:0]  count_q;
    logic [CntWidth-1:0]  count_next;
    logic                 ready_q;
    logic                 irq_q;
    logic                 push;
    logic                 pop;

    // Ready/valid come straight from registers; a full FIFO refuses pushes even during a pop.
    assign host_ready_o = ready_q && (count_q != Full);
    assign cl_valid_o   = (count_q != '0);
    assign cl_data_o    = mem[rd_ptr];
    assign count_o      = count_q;
    assign irq_o        = irq_q;

    assign push = host_valid_i && host_ready_o;
    assign pop  = cl_valid_o && cl_ready_i;

    // Occupancy after this edge; flush wins over any concurrent push or pop.
    always_comb begin
        count_next = count_q;
        if (flush_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_q + CntWidth'(1);
        end else if (pop && !push) begin
            count_next = count_q - CntWidth'(1);
        end
    end

    // Pointers, occupancy, startup ready and the doorbell, all cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ready_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PtrWidth'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PtrWidth'(1);
                end
            end
            count_q <= count_next;
            irq_q   <= irq_en_i && (irq_thresh_i != '0) && (count_next >= irq_thresh_i);
        end
    end

    // Storage array; contents are not reset, only the pointers are.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push && !flush_i) begin
            mem[wr_ptr] <= host_data_i;
        end
    end

`ifndef SYNTHESIS
    // A host word waiting for acceptance must stay valid and unchanged.
    property p_host_hold;
        @(posedge clk_i) disable iff (!rst_ni)
            (host_valid_i && !host_ready_o) |=> (host_valid_i && $stable(host_data_i));
    endproperty
    host_hold_a: assert property (p_host_hold);
`endif

endmodule

// File: tb/tb_konark_mailbox.sv
// Self-checking bench for konark_mailbox: a queue scoreboard tracks accepted words
// and is compared against the cluster port on every pop; occupancy, ready, valid
// and doorbell are checked against the bench's own model every cycle.
module tb_konark_mailbox;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] host_data;
    logic          host_valid;
    logic          host_ready;
    logic [DW-1:0] cl_data;
    logic          cl_valid;
    logic          cl_ready;
    logic          flush;
    logic          irq_en;
    logic [CW-1:0] irq_thresh;
    logic [CW-1:0] count;
    logic          irq;

    konark_mailbox #(
        .DataWidth(DW),
        .Depth    (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .host_data_i (host_data),
        .host_valid_i(host_valid),
        .host_ready_o(host_ready),
        .cl_data_o   (cl_data),
        .cl_valid_o  (cl_valid),
        .cl_ready_i  (cl_ready),
        .flush_i     (flush),
        .irq_en_i    (irq_en),
        .irq_thresh_i(irq_thresh),
        .count_o     (count),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   checks   = 0;
    int unsigned   failures = 0;
    logic [DW-1:0] q[$];
    bit            m_ready  = 1'b0;
    bit            m_irq    = 1'b0;
    bit            last_push;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs against the model at negedge, then advance the model at posedge.
    task automatic cycle();
        bit acc_push;
        bit acc_pop;
        @(negedge clk);
        check("host_ready", 32'(host_ready), 32'(m_ready && (q.size() != DEPTH)));
        check("cl_valid", 32'(cl_valid), 32'(q.size() != 0));
        check("count", 32'(count), 32'(q.size()));
        check("irq", 32'(irq), 32'(m_irq));
        acc_push = rst_n && host_valid && m_ready && (q.size() != DEPTH);
        acc_pop  = rst_n && cl_ready && (q.size() != 0);
        if (acc_pop) check("cl_data", cl_data, q[0]);
        last_push = acc_push;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_ready = 1'b0;
            m_irq   = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
            end else begin
                if (acc_pop) void'(q.pop_front());
                if (acc_push) q.push_back(host_data);
            end
            m_ready = 1'b1;
            m_irq   = irq_en && (irq_thresh != 0) && (q.size() >= int'(irq_thresh));
        end
        #1;
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        int budget;
        for (int i = 0; i < n; i++) begin
            budget     = 0;
            host_valid = 1'b1;
            host_data  = base + DW'(i);
            do begin
                cycle();
                budget++;
            end while (!last_push && budget < 50);
            if (!last_push) check("push_timeout", 32'(0), 32'(1));
        end
        host_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget   = 0;
        cl_ready = 1'b1;
        while (q.size() != 0 && budget < 50) begin
            cycle();
            budget++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'(0));
        cl_ready = 1'b0;
        cycle();
    endtask

    initial begin
        rst_n      = 1'b0;
        host_valid = 1'b1;
        host_data  = 32'h55;
        cl_ready   = 1'b0;
        flush      = 1'b0;
        irq_en     = 1'b0;
        irq_thresh = '0;
        @(posedge clk);
        #1;

        // Reset held with host_valid high
        repeat (3) cycle();
        check("rst_ready", 32'(host_ready), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_irq", 32'(irq), 32'(0));
        rst_n = 1'b1;
        check("rel_ready0", 32'(host_ready), 32'(0));
        cycle();
        check("rel_ready1", 32'(host_ready), 32'(1));
        cycle();
        host_valid = 1'b0;
        drain();

        // Fill to full, hold a 9th word, then pop at full
        push_words(32'h100, 8);
        check("fill_count", 32'(count), 32'(8));
        check("fill_ready", 32'(host_ready), 32'(0));
        host_valid = 1'b1;
        host_data  = 32'h108;
        cycle();
        cycle();
        check("held_count", 32'(count), 32'(8));
        cl_ready = 1'b1;
        cycle();
        check("fullpop_count", 32'(count), 32'(7));
        check("fullpop_ready", 32'(host_ready), 32'(1));
        cycle();
        host_valid = 1'b0;
        drain();
        check("drain_count", 32'(count), 32'(0));

        // Streaming 20 words with the cluster always ready
        cl_ready = 1'b1;
        push_words(32'h200, 20);
        drain();

        // Doorbell at threshold 3, then disabled threshold at full
        irq_en     = 1'b1;
        irq_thresh = CW'(3);
        push_words(32'h300, 2);
        check("irq_below", 32'(irq), 32'(0));
        push_words(32'h302, 1);
        check("irq_at3", 32'(irq), 32'(1));
        check("irq_cnt3", 32'(count), 32'(3));
        cl_ready = 1'b1;
        cycle();
        cl_ready = 1'b0;
        check("irq_cnt2", 32'(count), 32'(2));
        check("irq_off2", 32'(irq), 32'(0));
        irq_thresh = '0;
        push_words(32'h400, 6);
        cycle();
        check("thr0_cnt8", 32'(count), 32'(8));
        check("thr0_irq", 32'(irq), 32'(0));
        drain();

        // Flush at count 5 with concurrent push and pop
        irq_thresh = CW'(3);
        push_words(32'h500, 5);
        check("pre_flush_irq", 32'(irq), 32'(1));
        host_valid = 1'b1;
        host_data  = 32'h999;
        cl_ready   = 1'b1;
        flush      = 1'b1;
        cycle();
        flush      = 1'b0;
        host_valid = 1'b0;
        cl_ready   = 1'b0;
        check("flush_count", 32'(count), 32'(0));
        check("flush_valid", 32'(cl_valid), 32'(0));
        check("flush_irq", 32'(irq), 32'(0));
        push_words(32'hABC, 1);
        check("post_flush_head", cl_data, 32'hABC);
        check("post_flush_valid", 32'(cl_valid), 32'(1));
        drain();

        // Reset mid-operation discards buffered words
        push_words(32'h600, 2);
        rst_n = 1'b0;
        cycle();
        check("midrst_count", 32'(count), 32'(0));
        check("midrst_ready", 32'(host_ready), 32'(0));
        rst_n = 1'b1;
        cycle();
        push_words(32'h700, 3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
